// File: rtl/l2_pkg.sv
// Shared layer-2 constants used by the switch datapath blocks.
package l2_pkg;

  // Widest MAC address any block in the switch uses; blocks slice the low bits.
  localparam int MAX_ADDR_W = 48;

  // The all-ones address is broadcast at every address width.
  localparam logic [MAX_ADDR_W-1:0] BROADCAST_ADDR = '1;

  // Start-of-frame delimiter width and byte offsets of the Ethernet header fields.
  localparam int SFD_WIDTH    = 8;
  localparam int DST_OFFSET   = 0;
  localparam int SRC_OFFSET   = 6;
  localparam int ETYPE_OFFSET = 12;

  // Index width for a count of items, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/mac_aging_table_if.sv
// Request/response bundle between the switch ports and the MAC aging table.
interface mac_aging_table_if
  import l2_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int TABLE_SIZE = 16
);
  localparam int ING_W = clog2_min1(NUM_PORTS);
  localparam int CNT_W = $clog2(TABLE_SIZE) + 1;

  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_src;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_dst;
  logic [NUM_PORTS-1:0]            req_grant;
  logic                            flush;
  logic                            rsp_valid;
  logic [ING_W-1:0]                rsp_ingress;
  logic [NUM_PORTS-1:0]            rsp_fwd_mask;
  logic                            rsp_hit;
  logic [CNT_W-1:0]                entry_count;

  modport master (
    output req_valid, req_src, req_dst, flush,
    input  req_grant, rsp_valid, rsp_ingress, rsp_fwd_mask, rsp_hit, entry_count
  );

  modport slave (
    input  req_valid, req_src, req_dst, flush,
    output req_grant, rsp_valid, rsp_ingress, rsp_fwd_mask, rsp_hit, entry_count
  );

endinterface

// File: rtl/mac_aging_table_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, priority rotates past the winner.
module rr_arbiter
  import l2_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = clog2_min1(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic          found;
  int            idx;

  // Scan from the priority pointer and grant the first active request.
  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx[PW-1:0]]) begin
        found                = 1'b1;
        grant[idx[PW-1:0]]   = 1'b1;
        ptr_nxt              = PW'((idx + 1) % N);
      end
    end
  end

  // Move priority to the port after the winner once a grant is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= '0;
    else if (advance) ptr <= ptr_nxt;
  end

endmodule

// File: rtl/mac_aging_table.sv
// Learning MAC table with age-out, shared by all ingress ports through a
// round-robin arbiter; one lookup/learn per cycle, result registered.
module mac_aging_table
  import l2_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int TABLE_SIZE = 16,
  parameter int AGE_MAX    = 7,
  parameter int TICK_DIV   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  mac_aging_table_if.slave  bus
);
  localparam int ING_W  = clog2_min1(NUM_PORTS);
  localparam int CNT_W  = $clog2(TABLE_SIZE) + 1;
  localparam int AGE_W  = clog2_min1(AGE_MAX + 1);
  localparam int TICK_W = clog2_min1(TICK_DIV);
  localparam int IDX_W  = clog2_min1(TABLE_SIZE);
  localparam logic [ADDR_WIDTH-1:0] BCAST = BROADCAST_ADDR[ADDR_WIDTH-1:0];

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    return (a >= AGE_W'(AGE_MAX)) ? AGE_W'(AGE_MAX) : a + 1'b1;
  endfunction

  // Arbitration
  logic [NUM_PORTS-1:0]  arb_req;
  logic [NUM_PORTS-1:0]  grant;
  logic                  gnt_any;
  logic [ING_W-1:0]      sel_port;
  logic [ADDR_WIDTH-1:0] sel_src;
  logic [ADDR_WIDTH-1:0] sel_dst;

  // Table state
  logic [TABLE_SIZE-1:0] ent_vld;
  logic [ADDR_WIDTH-1:0] ent_mac  [TABLE_SIZE];
  logic [ING_W-1:0]      ent_port [TABLE_SIZE];
  logic [AGE_W-1:0]      ent_age  [TABLE_SIZE];
  logic [CNT_W-1:0]      ent_cnt;
  logic [TICK_W-1:0]     tick_cnt;
  logic                  tick;

  // Lookup / learn decisions
  logic                  dst_hit;
  logic [ING_W-1:0]      dst_port;
  logic                  src_hit;
  logic [IDX_W-1:0]      src_idx;
  logic                  free_found;
  logic [IDX_W-1:0]      free_idx;
  logic [IDX_W-1:0]      old_idx;
  logic [AGE_W-1:0]      old_age;
  logic                  learn_en;
  logic [IDX_W-1:0]      learn_idx;
  logic [NUM_PORTS-1:0]  fwd_mask;
  logic                  fwd_hit;
  logic [NUM_PORTS-1:0]  all_but_ing;

  // Next table state
  logic [TABLE_SIZE-1:0] vld_nxt;
  logic [AGE_W-1:0]      age_nxt [TABLE_SIZE];
  logic [CNT_W-1:0]      cnt_nxt;

  // Response pipeline
  logic                  vld_p1;
  logic [ING_W-1:0]      ing_p1;
  logic [NUM_PORTS-1:0]  mask_p1;
  logic                  hit_p1;

  // Flush blocks every grant so no learn can race the table clear.
  assign arb_req       = bus.flush ? '0 : bus.req_valid;
  assign gnt_any       = |grant;
  assign bus.req_grant = grant;

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (gnt_any),
    .grant   (grant)
  );

  // Mux the winning port's addresses onto the shared lookup path.
  always_comb begin
    sel_port = '0;
    sel_src  = '0;
    sel_dst  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        sel_port = ING_W'(p);
        sel_src  = bus.req_src[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_dst  = bus.req_dst[p*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Associative search over the current (pre-update) table contents.
  always_comb begin
    dst_hit    = 1'b0;
    dst_port   = '0;
    src_hit    = 1'b0;
    src_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    old_idx    = '0;
    old_age    = ent_age[0];
    for (int e = 0; e < TABLE_SIZE; e++) begin
      if (ent_vld[e] && ent_mac[e] == sel_dst && !dst_hit) begin
        dst_hit  = 1'b1;
        dst_port = ent_port[e];
      end
      if (ent_vld[e] && ent_mac[e] == sel_src && !src_hit) begin
        src_hit = 1'b1;
        src_idx = IDX_W'(e);
      end
      if (!ent_vld[e] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(e);
      end
      // Strict compare keeps the lowest index among equally old entries.
      if (e > 0 && ent_age[e] > old_age) begin
        old_age = ent_age[e];
        old_idx = IDX_W'(e);
      end
    end
  end

  // Pick the entry to learn into: refresh, else first free, else oldest.
  always_comb begin
    learn_en  = gnt_any && (sel_src != BCAST);
    learn_idx = src_hit ? src_idx : (free_found ? free_idx : old_idx);
  end

  // Forwarding decision for the granted request.
  always_comb begin
    all_but_ing = ~(NUM_PORTS'(1) << sel_port);
    fwd_mask    = all_but_ing;
    fwd_hit     = 1'b0;
    if (sel_dst != BCAST && dst_hit) begin
      fwd_hit  = 1'b1;
      fwd_mask = (dst_port == sel_port) ? '0 : (NUM_PORTS'(1) << dst_port);
    end
  end

  // Free-running age tick.
  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  // Age tick divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Per-entry next state: flush beats learn, learn beats the age tick.
  always_comb begin
    cnt_nxt = '0;
    for (int e = 0; e < TABLE_SIZE; e++) begin
      vld_nxt[e] = ent_vld[e];
      age_nxt[e] = ent_age[e];
      if (bus.flush) begin
        vld_nxt[e] = 1'b0;
        age_nxt[e] = '0;
      end else if (learn_en && learn_idx == IDX_W'(e)) begin
        vld_nxt[e] = 1'b1;
        age_nxt[e] = '0;
      end else if (tick && ent_vld[e]) begin
        if (ent_age[e] == AGE_W'(AGE_MAX)) begin
          vld_nxt[e] = 1'b0;
          age_nxt[e] = '0;
        end else begin
          age_nxt[e] = age_sat_inc(ent_age[e]);
        end
      end
      cnt_nxt = cnt_nxt + CNT_W'(vld_nxt[e]);
    end
  end

  // Table control state and the occupancy count move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_vld <= '0;
      ent_cnt <= '0;
      for (int e = 0; e < TABLE_SIZE; e++) ent_age[e] <= '0;
    end else begin
      ent_vld <= vld_nxt;
      ent_cnt <= cnt_nxt;
      for (int e = 0; e < TABLE_SIZE; e++) ent_age[e] <= age_nxt[e];
    end
  end

  // Address and port payload is only meaningful while the valid bit is set.
  always_ff @(posedge clk) begin
    if (learn_en && !bus.flush) begin
      ent_mac[learn_idx]  <= sel_src;
      ent_port[learn_idx] <= sel_port;
    end
  end

  // ---- stage p0 -> p1: register the forwarding result ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      ing_p1  <= '0;
      mask_p1 <= '0;
      hit_p1  <= 1'b0;
    end else begin
      vld_p1 <= gnt_any;
      if (gnt_any) begin
        ing_p1  <= sel_port;
        mask_p1 <= fwd_mask;
        hit_p1  <= fwd_hit;
      end
    end
  end

  assign bus.rsp_valid    = vld_p1;
  assign bus.rsp_ingress  = ing_p1;
  assign bus.rsp_fwd_mask = mask_p1;
  assign bus.rsp_hit      = hit_p1;
  assign bus.entry_count  = ent_cnt;

endmodule

// File: doc/mac_aging_table.md
MAC_AGING_TABLE -- requirements
Module: mac_aging_table

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of switch ports requesting lookups.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, MAC address width; all-ones is broadcast.
REQ-003 SHALL have parameter TABLE_SIZE, default 16, number of table entries.
REQ-004 SHALL have parameter AGE_MAX, default 7, age ticks after which an unrefreshed entry is removed.
REQ-005 SHALL have parameter TICK_DIV, default 1024, clock cycles per age tick.
REQ-006 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port req_valid, input, NUM_PORTS, per-ingress-port lookup/learn request.
REQ-009 SHALL have port req_src, input, NUM_PORTS*ADDR_WIDTH, source MAC per port; port i occupies slice i.
REQ-010 SHALL have port req_dst, input, NUM_PORTS*ADDR_WIDTH, destination MAC per port; port i occupies slice i.
REQ-011 SHALL have port req_grant, output, NUM_PORTS, one-hot combinational acceptance.
REQ-012 SHALL have port flush, input, 1, clears the whole table.
REQ-013 SHALL have port rsp_valid, output, 1, registered result strobe.
REQ-014 SHALL have port rsp_ingress, output, clog2(NUM_PORTS), ingress port of the result.
REQ-015 SHALL have port rsp_fwd_mask, output, NUM_PORTS, egress ports to write.
REQ-016 SHALL have port rsp_hit, output, 1, destination found in the table.
REQ-017 SHALL have port entry_count, output, clog2(TABLE_SIZE)+1, number of valid entries.

Function
REQ-018 SHALL grant at most one request per cycle by round-robin; after a grant to port i, port i+1 (mod NUM_PORTS) has the highest priority.
REQ-019 SHALL hold req_grant at zero while flush is high.
REQ-020 SHALL keep requesters holding req_valid and their slices stable until granted; a deasserted request SHALL be forgotten.
REQ-021 SHALL present the result of a request granted in cycle N with rsp_valid=1 in cycle N+1, pulsed for one cycle.
REQ-022 SHALL perform destination lookup on the table contents before the same-cycle learn update.
REQ-023 SHALL forward a broadcast destination to all ports except ingress (rsp_hit=0).
REQ-024 SHALL forward a hit on another port to that port only (one-hot mask, rsp_hit=1).
REQ-025 SHALL filter a hit on the ingress port (mask 0, rsp_hit=1).
REQ-026 SHALL forward a miss to all ports except ingress (rsp_hit=0).
REQ-027 SHALL never learn a broadcast source address.
REQ-028 SHALL, on a source hit, set the entry port to the ingress port and reset its age to 0.
REQ-029 SHALL, on a source miss, allocate the lowest-index invalid entry with age 0.
REQ-030 SHALL, on a source miss with the table full, overwrite the entry with the highest age (lowest index on tie).
REQ-031 SHALL assert an age tick every TICK_DIV cycles from a free-running counter.
REQ-032 SHALL, on each age tick, increment the age of every valid entry, saturating at AGE_MAX.
REQ-033 SHALL invalidate a valid entry whose age equals AGE_MAX when a tick occurs.
REQ-034 SHALL give a same-cycle learn priority over a tick on the same entry (age 0, stays valid).
REQ-035 SHALL invalidate all entries on the cycle after flush is sampled high; flush SHALL override a same-cycle learn.
REQ-036 SHALL keep entry_count equal to the number of valid entries, registered and updated with the table.

Reset
REQ-037 SHALL on rst clear all valid bits, ages, the tick counter and the arbiter pointer (port 0 highest priority).
REQ-038 SHALL on rst drive rsp_valid=0, rsp_fwd_mask=0, rsp_hit=0, rsp_ingress=0 and entry_count=0.
REQ-039 SHALL on reset asserted mid-request discard any in-flight result.

Structure
REQ-040 SHALL take BROADCAST_ADDR, SFD_WIDTH and frame field offset constants from shared package l2_pkg.
REQ-041 SHALL implement round-robin grant in sub-module rr_arbiter (parameter N, inputs req and advance, output one-hot grant).

Verification
REQ-042 SHALL verify learn then forward: port0 src=3 dst=F; then port2 src=5 dst=3 -> mask 0001, hit=1.
REQ-043 SHALL verify miss flood: port1 dst=9, table empty -> mask 1101, hit=0, entry_count=1.
REQ-044 SHALL verify contention: all four req_valid high for 4 cycles -> grants 0,1,2,3, one per cycle, results in grant order.
REQ-045 SHALL verify aging with TICK_DIV=4, AGE_MAX=2: learn src=3, idle 12 cycles -> entry invalid, dst=3 floods.
REQ-046 SHALL verify a full table with TABLE_SIZE=4: learn 4 sources, refresh 3, learn a fifth -> the unrefreshed entry is replaced and entry_count=4.
REQ-047 SHALL verify flush with simultaneous request: flush=1 with req_valid=0001 -> no grant, entry_count=0 next cycle.
